intpol_lin_mc_core: RTL and testbench



---
 rtl/intpol_lin_mc_core.sv | 176 +++++++++++++++++
 tb/tb_intpol_lin_mc_core.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intpol_lin_mc_core.sv
// Multi-channel linear interpolator: each queued frame yields 2^log2_l output frames stepping from the previous frame.
// First output two cycles after a frame load, then one per cycle; Afull_i stalls output in place, Afull_o warns the writer.
module intpol_lin_mc_core #(
    parameter int DATA_WIDTH   = 16,
    parameter int CHANNELS     = 2,
    parameter int FIFO_DEPTH   = 16,
    parameter int LOG2_L_MAX   = 4,
    parameter int AFULL_MARGIN = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [3:0]                     conf_log2_l,
    input  logic [15:0]                    conf_nframes,
    input  logic                           Write_Enable_fifo_i,
    input  logic [CHANNELS*DATA_WIDTH-1:0] data_in_fifo,
    output logic                           Afull_o,
    input  logic                           Afull_i,
    output logic [CHANNELS*DATA_WIDTH-1:0] data_out,
    output logic                           valid_out,
    output logic                           busy,
    output logic                           overflow,
    output logic                           int_req
);
    localparam int FW = DATA_WIDTH * CHANNELS;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int KW = (LOG2_L_MAX > 0) ? LOG2_L_MAX : 1;
    localparam int PW = DATA_WIDTH + 1 + KW;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_WAIT, S_DONE} state_t;

    state_t          state_q;
    logic [FW-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q;
    logic            overflow_q;
    logic [FW-1:0]   x0_q, x1_q, data_out_q, interp, head;
    logic [KW-1:0]   k_q;
    logic [3:0]      log2_l_q, log2_l_d;
    logic [15:0]     nframes_q, nframes_d, frame_cnt_q;
    logic            valid_q, int_req_q;
    logic            fifo_full, fifo_empty, push_ok, pop, k_last;
    logic [KW:0]     l_full;
    logic signed [PW-1:0] k_ext;

    assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign head       = mem_q[rd_ptr_q];
    assign l_full     = (KW+1)'(1) << log2_l_q;
    assign k_last     = (k_q == KW'(l_full - 1'b1));
    assign k_ext      = {{(PW-KW){1'b0}}, k_q};
    assign log2_l_d   = (conf_log2_l > 4'(LOG2_L_MAX)) ? 4'(LOG2_L_MAX) : conf_log2_l;
    assign nframes_d  = (conf_nframes == '0) ? 16'd1 : conf_nframes;

    // Pop on LOAD, or on the last phase of a segment when another frame is waiting (no bubble).
    assign pop = (state_q == S_LOAD) ||
                 (state_q == S_RUN && !Afull_i && k_last &&
                  frame_cnt_q != nframes_q && !fifo_empty);
    assign push_ok = Write_Enable_fifo_i && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_in_fifo;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (Write_Enable_fifo_i && !push_ok)
                overflow_q <= 1'b1;
            else if (start && state_q == S_IDLE)
                overflow_q <= 1'b0;
        end
    end

    // Per channel: x0 + floor((x1 - x0) * k / L); result lies between x0 and x1 so truncation is exact.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic signed [DATA_WIDTH-1:0] a, b;
        logic signed [DATA_WIDTH:0]   diff;
        logic signed [PW-1:0]         prod, shifted;
        assign a       = x0_q[c*DATA_WIDTH +: DATA_WIDTH];
        assign b       = x1_q[c*DATA_WIDTH +: DATA_WIDTH];
        assign diff    = (DATA_WIDTH+1)'(b) - (DATA_WIDTH+1)'(a);
        assign prod    = PW'(diff) * k_ext;
        assign shifted = prod >>> log2_l_q;
        assign interp[c*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(PW'(a) + shifted);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            x0_q        <= '0;
            x1_q        <= '0;
            k_q         <= '0;
            frame_cnt_q <= '0;
            nframes_q   <= '0;
            log2_l_q    <= '0;
            data_out_q  <= '0;
            valid_q     <= 1'b0;
            int_req_q   <= 1'b0;
        end else begin
            int_req_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    valid_q <= 1'b0;
                    if (start) begin
                        log2_l_q    <= log2_l_d;
                        nframes_q   <= nframes_d;
                        x0_q        <= '0;
                        x1_q        <= '0;
                        k_q         <= '0;
                        frame_cnt_q <= '0;
                        state_q     <= fifo_empty ? S_WAIT : S_LOAD;
                    end
                end
                S_LOAD: begin
                    valid_q     <= 1'b0;
                    x0_q        <= x1_q;
                    x1_q        <= head;
                    frame_cnt_q <= frame_cnt_q + 1'b1;
                    k_q         <= '0;
                    state_q     <= S_RUN;
                end
                S_RUN: begin
                    if (Afull_i) begin
                        valid_q <= 1'b0;
                    end else begin
                        data_out_q <= interp;
                        valid_q    <= 1'b1;
                        k_q        <= k_q + 1'b1;
                        if (k_last) begin
                            if (frame_cnt_q == nframes_q) begin
                                state_q <= S_DONE;
                            end else if (!fifo_empty) begin
                                x0_q        <= x1_q;
                                x1_q        <= head;
                                frame_cnt_q <= frame_cnt_q + 1'b1;
                                k_q         <= '0;
                            end else begin
                                state_q <= S_WAIT;
                            end
                        end
                    end
                end
                S_WAIT: begin
                    valid_q <= 1'b0;
                    if (!fifo_empty) state_q <= S_LOAD;
                end
                S_DONE: begin
                    valid_q   <= 1'b0;
                    int_req_q <= 1'b1;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_q;
    assign int_req   = int_req_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q != S_IDLE);
    assign Afull_o   = (count_q >= (AW+1)'(FIFO_DEPTH - AFULL_MARGIN));

endmodule

// File: tb/tb_intpol_lin_mc_core.sv
// Directed bench for intpol_lin_mc_core with hand-computed expected sequences.
module tb_intpol_lin_mc_core;
    localparam int DW = 16;
    localparam int CH = 2;
    localparam int FW = DW * CH;

    logic          clk = 1'b0;
    logic          rst, start, we, Afull_i;
    logic [3:0]    conf_log2_l;
    logic [15:0]   conf_nframes;
    logic [FW-1:0] din, data_out;
    logic          Afull_o, valid_out, busy, overflow, int_req;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int irq_cnt  = 0;
    int irq_at   = 0;
    logic [FW-1:0] out_q [$];
    int            vcyc_q [$];

    intpol_lin_mc_core #(
        .DATA_WIDTH(16), .CHANNELS(2), .FIFO_DEPTH(16), .LOG2_L_MAX(4), .AFULL_MARGIN(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .conf_log2_l(conf_log2_l),
        .conf_nframes(conf_nframes), .Write_Enable_fifo_i(we), .data_in_fifo(din),
        .Afull_o(Afull_o), .Afull_i(Afull_i), .data_out(data_out), .valid_out(valid_out),
        .busy(busy), .overflow(overflow), .int_req(int_req)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_out) begin
            out_q.push_back(data_out);
            vcyc_q.push_back(cyc);
        end
        if (int_req) begin
            irq_cnt = irq_cnt + 1;
            irq_at  = out_q.size();
        end
    end

    function automatic int chv(input logic [FW-1:0] w, input int c);
        logic signed [DW-1:0] s;
        s = w[c*DW +: DW];
        return int'(s);
    endfunction

    function automatic int outv(input int idx, input int c);
        if (idx < out_q.size()) return chv(out_q[idx], c);
        return 99999;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int a, input int b);
        we  = 1'b1;
        din = {16'(b), 16'(a)};
        tick();
        we  = 1'b0;
    endtask

    task automatic do_start(input int l2, input int n);
        start        = 1'b1;
        conf_log2_l  = 4'(l2);
        conf_nframes = 16'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy && n < 2000) begin
            tick();
            n++;
        end
        repeat (2) tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_timeout: busy=%0b required 0", nm, busy);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({valid_out, busy, overflow, int_req, Afull_o} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b required 00000", {valid_out, busy, overflow, int_req, Afull_o});
        end
        checks++;
        if (data_out !== '0) begin
            failures++;
            $display("FAIL reset_data: got %h required 0", data_out);
        end
    endtask

    task automatic test_basic();
        int e0 [12] = '{0, 0, 0, 0, 0, 25, 50, 75, 100, 125, 150, 175};
        int e1 [12] = '{0, 0, 0, 0, 0, -10, -20, -30, -40, -20, 0, 20};
        int base, ib, s;
        base = out_q.size();
        ib   = irq_cnt;
        push(0, 0);
        push(100, -40);
        push(200, 40);
        do_start(2, 3);
        s = cyc;
        wait_idle("basic");
        checks++;
        if (out_q.size() - base !== 12) begin
            failures++;
            $display("FAIL basic_count: got %0d required 12", out_q.size() - base);
        end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (outv(base + i, 0) !== e0[i] || outv(base + i, 1) !== e1[i]) begin
                failures++;
                $display("FAIL basic_out[%0d]: got %0d/%0d required %0d/%0d",
                         i, outv(base + i, 0), outv(base + i, 1), e0[i], e1[i]);
            end
        end
        checks++;
        if (vcyc_q.size() <= base || vcyc_q[base] !== s + 2) begin
            failures++;
            $display("FAIL basic_latency: first valid cycle %0d required %0d",
                     (vcyc_q.size() > base) ? vcyc_q[base] : -1, s + 2);
        end
        checks++;
        if (irq_cnt - ib !== 1 || irq_at - base !== 12) begin
            failures++;
            $display("FAIL basic_irq: pulses=%0d at_valid=%0d required 1 and 12", irq_cnt - ib, irq_at - base);
        end
    endtask

    task automatic test_signs();
        int a0 [8] = '{0, 25, 50, 75, 100, 50, 0, -50};
        int a1 [8] = '{0, 0, 0, 0, 0, -1, -2, -3};
        int b0 [4] = '{0, 0, 0, -2};
        int base;
        base = out_q.size();
        push(100, 0);
        push(-100, -3);
        do_start(2, 2);
        wait_idle("signs_a");
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (outv(base + i, 0) !== a0[i] || outv(base + i, 1) !== a1[i]) begin
                failures++;
                $display("FAIL signs_out[%0d]: got %0d/%0d required %0d/%0d",
                         i, outv(base + i, 0), outv(base + i, 1), a0[i], a1[i]);
            end
        end
        base = out_q.size();
        push(0, 0);
        push(-3, 0);
        do_start(1, 2);
        wait_idle("floor");
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (outv(base + i, 0) !== b0[i]) begin
                failures++;
                $display("FAIL floor_out[%0d]: got %0d required %0d", i, outv(base + i, 0), b0[i]);
            end
        end
    endtask

    task automatic test_afull();
        int base, n, e;
        base = out_q.size();
        push(0, 0);
        push(160, 0);
        do_start(3, 2);
        n = 0;
        while (!(valid_out === 1'b1 && chv(data_out, 0) == 40) && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 200) begin
            failures++;
            $display("FAIL afull_reach: value 40 not seen, required within 200 cycles");
        end
        Afull_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (valid_out !== 1'b0 || chv(data_out, 0) !== 40) begin
                failures++;
                $display("FAIL afull_hold[%0d]: valid=%0b data=%0d required 0 and 40", i, valid_out, chv(data_out, 0));
            end
        end
        Afull_i = 1'b0;
        wait_idle("afull");
        checks++;
        if (out_q.size() - base !== 16) begin
            failures++;
            $display("FAIL afull_count: got %0d required 16", out_q.size() - base);
        end
        for (int i = 0; i < 16; i++) begin
            e = (i < 8) ? 0 : 20 * (i - 8);
            checks++;
            if (outv(base + i, 0) !== e) begin
                failures++;
                $display("FAIL afull_out[%0d]: got %0d required %0d", i, outv(base + i, 0), e);
            end
        end
    endtask

    task automatic test_fifo();
        int base, n;
        logic exp_af, exp_ov;
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            push(i, -i);
            exp_af = (((i > 16) ? 16 : i) >= 12);
            exp_ov = (i == 17);
            checks++;
            if (Afull_o !== exp_af || overflow !== exp_ov) begin
                failures++;
                $display("FAIL fifo_push[%0d]: afull=%0b ovf=%0b required %0b %0b", i, Afull_o, overflow, exp_af, exp_ov);
            end
        end
        base = out_q.size();
        do_start(0, 17);
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL fifo_ovf_clear: got %0b required 0", overflow);
        end
        n = 0;
        while (out_q.size() - base < 16 && n < 100) begin
            tick();
            n++;
        end
        repeat (3) tick();
        checks++;
        if (out_q.size() - base !== 16 || busy !== 1'b1) begin
            failures++;
            $display("FAIL fifo_drain: outputs=%0d busy=%0b required 16 and 1", out_q.size() - base, busy);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (outv(base + i, 0) !== i) begin
                failures++;
                $display("FAIL fifo_out[%0d]: got %0d required %0d", i, outv(base + i, 0), i);
            end
        end
        push(55, 0);
        wait_idle("fifo");
        checks++;
        if (out_q.size() - base !== 17 || outv(base + 16, 0) !== 16 || Afull_o !== 1'b0) begin
            failures++;
            $display("FAIL fifo_tail: outputs=%0d last=%0d afull=%0b required 17, 16, 0",
                     out_q.size() - base, outv(base + 16, 0), Afull_o);
        end
    endtask

    task automatic test_reset_mid();
        int base, n;
        for (int i = 1; i <= 6; i++) push(10 * i, 0);
        do_start(4, 6);
        n = 0;
        while (!(valid_out === 1'b1 && chv(data_out, 0) != 0) && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 200) begin
            failures++;
            $display("FAIL rstmid_reach: nonzero output not seen, required within 200 cycles");
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({valid_out, busy, overflow, int_req, Afull_o} !== 5'b0 || data_out !== '0) begin
            failures++;
            $display("FAIL rstmid_outputs: flags=%b data=%h required 00000 and 0",
                     {valid_out, busy, overflow, int_req, Afull_o}, data_out);
        end
        rst = 1'b0;
        base = out_q.size();
        do_start(0, 1);
        repeat (4) tick();
        checks++;
        if (busy !== 1'b1 || out_q.size() !== base) begin
            failures++;
            $display("FAIL rstmid_empty: busy=%0b outputs=%0d required 1 and 0", busy, out_q.size() - base);
        end
        push(7, 0);
        wait_idle("rstmid");
        checks++;
        if (out_q.size() - base !== 1 || outv(base, 0) !== 0) begin
            failures++;
            $display("FAIL rstmid_job: outputs=%0d first=%0d required 1 and 0", out_q.size() - base, outv(base, 0));
        end
    endtask

    task automatic test_back_to_back();
        int base, ib, e, span;
        base = out_q.size();
        ib   = irq_cnt;
        push(0, 0);
        push(160, 0);
        do_start(7, 2);
        repeat (5) tick();
        start        = 1'b1;
        conf_log2_l  = 4'd0;
        conf_nframes = 16'd1;
        tick();
        start = 1'b0;
        wait_idle("b2b");
        checks++;
        if (out_q.size() - base !== 32) begin
            failures++;
            $display("FAIL b2b_count: got %0d required 32", out_q.size() - base);
        end
        for (int i = 0; i < 32; i++) begin
            e = (i < 16) ? 0 : 10 * (i - 16);
            checks++;
            if (outv(base + i, 0) !== e) begin
                failures++;
                $display("FAIL b2b_out[%0d]: got %0d required %0d", i, outv(base + i, 0), e);
            end
        end
        span = (vcyc_q.size() >= base + 32) ? vcyc_q[base + 31] - vcyc_q[base] : -1;
        checks++;
        if (span !== 31 || irq_cnt - ib !== 1) begin
            failures++;
            $display("FAIL b2b_continuous: span=%0d irqs=%0d required 31 and 1", span, irq_cnt - ib);
        end
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        we           = 1'b0;
        din          = '0;
        Afull_i      = 1'b0;
        conf_log2_l  = '0;
        conf_nframes = '0;
        test_reset();
        test_basic();
        test_signs();
        test_afull();
        test_fifo();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
